operand_fetch_ctrl: RTL

//  Drives the register file's read/write ports: takes operand requests (rs1, rs2, rd) upstream, fetches both

---
 rtl/operand_fetch_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/operand_fetch_ctrl.sv
// Operand fetch controller: issues register reads, hands operands to execute over valid/ready,
// routes writebacks into the register file and tracks pending destinations in a scoreboard.
module operand_fetch_ctrl #(
  parameter int DW = 72,
  parameter int AW = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AW-1:0]        in_rs1,
  input  logic [AW-1:0]        in_rs2,
  input  logic [AW-1:0]        in_rd,
  input  logic                 in_rd_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_op1,
  output logic [DW-1:0]        out_op2,
  output logic [AW-1:0]        out_rd,
  output logic                 out_rd_en,
  input  logic                 wb_valid,
  input  logic [AW-1:0]        wb_addr,
  input  logic [DW-1:0]        wb_data,
  output logic                 rf_write,
  output logic [AW-1:0]        rf_reg1_address,
  output logic [AW-1:0]        rf_reg2_address,
  output logic [AW-1:0]        rf_reg_r_address,
  output logic [DW-1:0]        rf_result_in,
  input  logic [DW-1:0]        rf_data_out1,
  input  logic [DW-1:0]        rf_data_out2,
  output logic [(1<<AW)-1:0]   busy_mask,
  output logic                 wb_unexpected
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] READ    = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] HOLD    = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [AW-1:0]       rs1_q, rs1_d;
  logic [AW-1:0]       rs2_q, rs2_d;
  logic [AW-1:0]       rd_q, rd_d;
  logic                rd_en_q, rd_en_d;
  logic                out_valid_q, out_valid_d;
  logic [DW-1:0]       op1_q, op1_d;
  logic [DW-1:0]       op2_q, op2_d;
  logic [AW-1:0]       out_rd_q, out_rd_d;
  logic                out_rd_en_q, out_rd_en_d;
  logic [(1<<AW)-1:0]  busy_q, busy_d;
  logic                wb_unexpected_q, wb_unexpected_d;
  logic                hazard;
  logic                accept;

  // Hazards use only the registered scoreboard; a writeback frees its register one cycle later.
  assign hazard   = busy_q[in_rs1] | busy_q[in_rs2] | (in_rd_en & busy_q[in_rd]);
  assign in_ready = (state_q == IDLE) & ~hazard;
  assign accept   = in_valid & in_ready;

  assign rf_write         = wb_valid;
  assign rf_reg_r_address = wb_addr;
  assign rf_result_in     = wb_data;
  assign rf_reg1_address  = rs1_q;
  assign rf_reg2_address  = rs2_q;

  assign out_valid     = out_valid_q;
  assign out_op1       = op1_q;
  assign out_op2       = op2_q;
  assign out_rd        = out_rd_q;
  assign out_rd_en     = out_rd_en_q;
  assign busy_mask     = busy_q;
  assign wb_unexpected = wb_unexpected_q;

  always_comb begin
    state_d     = state_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    rd_en_d     = rd_en_q;
    out_valid_d = out_valid_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    out_rd_d    = out_rd_q;
    out_rd_en_d = out_rd_en_q;
    busy_d      = busy_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          rs1_d   = in_rs1;
          rs2_d   = in_rs2;
          rd_d    = in_rd;
          rd_en_d = in_rd_en;
          state_d = READ;
        end
      end
      // A writeback edge makes the register file write instead of read, so retry.
      READ: begin
        if (!wb_valid) state_d = CAPTURE;
      end
      CAPTURE: begin
        op1_d       = rf_data_out1;
        op2_d       = rf_data_out2;
        out_rd_d    = rd_q;
        out_rd_en_d = rd_en_q;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Clear first so a same-edge set of the same register wins.
    if (wb_valid) busy_d[wb_addr] = 1'b0;
    if (accept && in_rd_en) busy_d[in_rd] = 1'b1;
  end

  assign wb_unexpected_d = wb_valid & ~busy_q[wb_addr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      rs1_q           <= '0;
      rs2_q           <= '0;
      rd_q            <= '0;
      rd_en_q         <= 1'b0;
      out_valid_q     <= 1'b0;
      op1_q           <= '0;
      op2_q           <= '0;
      out_rd_q        <= '0;
      out_rd_en_q     <= 1'b0;
      busy_q          <= '0;
      wb_unexpected_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      rs1_q           <= rs1_d;
      rs2_q           <= rs2_d;
      rd_q            <= rd_d;
      rd_en_q         <= rd_en_d;
      out_valid_q     <= out_valid_d;
      op1_q           <= op1_d;
      op2_q           <= op2_d;
      out_rd_q        <= out_rd_d;
      out_rd_en_q     <= out_rd_en_d;
      busy_q          <= busy_d;
      wb_unexpected_q <= wb_unexpected_d;
    end
  end

endmodule
